// File: rtl/snn_image_loader.sv
// Writer side of the snn_core input RAM: unpacks UART bytes into pixels,
// starts the core on a full frame and returns the digit as ASCII.
module snn_image_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10,
    parameter int NUM_BYTES  = 98
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              ram_we,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              overflow
);

    localparam int BC_W = ADDR_W - 3;

    typedef enum logic [2:0] {
        S_LOAD,
        S_UNPACK,
        S_START,
        S_WAIT,
        S_TX
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [BC_W-1:0]   byte_cnt;
    logic [2:0]        bit_cnt;
    logic [7:0]        shift;
    logic              pend_valid;
    logic [7:0]        pend_data;
    logic [ADDR_W-1:0] pix_addr;
    logic              last_pixel;
    logic              last_byte;

    function automatic logic [7:0] to_ascii(input logic [3:0] d);
        if (d > 4'd9)
            return 8'h3F;
        return 8'h30 + {4'h0, d};
    endfunction

    assign pix_addr   = {byte_cnt, bit_cnt};
    assign last_pixel = (pix_addr == ADDR_W'(NUM_PIXELS - 1));
    assign last_byte  = (byte_cnt == BC_W'(NUM_BYTES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_LOAD;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_LOAD: begin
                if (pend_valid || rx_rdy)
                    state_nxt = S_UNPACK;
            end
            S_UNPACK: begin
                if (bit_cnt == 3'd7)
                    state_nxt = last_pixel ? S_START : S_LOAD;
            end
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (core_done)
                    state_nxt = S_TX;
            end
            S_TX: begin
                if (!tx_busy)
                    state_nxt = S_LOAD;
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            overflow   <= 1'b0;
            tx_data    <= '0;
        end else begin
            unique case (state)
                S_LOAD: begin
                    bit_cnt <= '0;
                    // Pending byte is older, so it goes first; a fresh
                    // byte arriving alongside refills the pending slot.
                    if (pend_valid) begin
                        shift <= pend_data;
                        if (rx_rdy)
                            pend_data <= rx_data;
                        else
                            pend_valid <= 1'b0;
                    end else if (rx_rdy) begin
                        shift <= rx_data;
                    end
                end
                S_UNPACK: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
                    if (rx_rdy) begin
                        if (pend_valid) begin
                            overflow <= 1'b1;
                        end else begin
                            pend_valid <= 1'b1;
                            pend_data  <= rx_data;
                        end
                    end
                end
                S_START: begin
                    if (rx_rdy)
                        overflow <= 1'b1;
                end
                S_WAIT: begin
                    if (rx_rdy)
                        overflow <= 1'b1;
                    if (core_done)
                        tx_data <= to_ascii(core_digit);
                end
                S_TX: begin
                    if (rx_rdy)
                        overflow <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_data   = 1'b0;
        core_start = 1'b0;
        tx_start   = 1'b0;
        busy       = 1'b1;
        unique case (state)
            S_LOAD: begin
                busy = (byte_cnt != '0) || pend_valid;
            end
            S_UNPACK: begin
                ram_we   = 1'b1;
                ram_addr = pix_addr;
                ram_data = shift[bit_cnt];
            end
            S_START: core_start = 1'b1;
            S_WAIT:  ;
            S_TX:    tx_start = !tx_busy;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_snn_image_loader.sv
// Directed bench for snn_image_loader: pixel unpacking, pending byte,
// overflow, frame completion, result transmission and mid-frame reset.
module tb_snn_image_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = '0;
    logic [9:0] ram_addr;
    logic       ram_data;
    logic       ram_we;
    logic       core_start;
    logic       core_done = 1'b0;
    logic [3:0] core_digit = '0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       busy;
    logic       overflow;

    int n_tests = 0;
    int n_fail  = 0;

    snn_image_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_we     (ram_we),
        .core_start (core_start),
        .core_done  (core_done),
        .core_digit (core_digit),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .busy       (busy),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         wr_n = 0;
    int         cs_n = 0;
    int         cs_cyc = 0;
    int         tx_n = 0;
    logic [7:0] tx_last = '0;
    logic [9:0] wr_addr [0:4095];
    logic       wr_dat  [0:4095];
    int         wr_cyc  [0:4095];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ram_we && wr_n < 4096) begin
            wr_addr[wr_n] <= ram_addr;
            wr_dat[wr_n]  <= ram_data;
            wr_cyc[wr_n]  <= cyc;
            wr_n          <= wr_n + 1;
        end
        if (core_start) begin
            cs_n   <= cs_n + 1;
            cs_cyc <= cyc;
        end
        if (tx_start) begin
            tx_n    <= tx_n + 1;
            tx_last <= tx_data;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        rx_rdy = 1'b0;
        core_done = 1'b0;
        tx_busy = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (9) tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({ram_we, ram_data, core_start, tx_start} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got=%b want=0000",
                     {ram_we, ram_data, core_start, tx_start});
        end
        n_tests++;
        if (ram_addr !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_addr got=%h want=000", ram_addr);
        end
        n_tests++;
        if (tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_tx_data got=%h want=00", tx_data);
        end
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({busy, overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_busy_ovf got=%b want=00", {busy, overflow});
        end
    endtask

    task automatic test_single_byte;
        int base;
        int t;
        int errs;
        base = wr_n;
        t = cyc;
        send_byte(8'h01);
        n_tests++;
        if (wr_n - base !== 8) begin
            n_fail++;
            $display("FAIL single_count got=%0d want=8", wr_n - base);
        end
        n_tests++;
        if (wr_cyc[base] !== t + 1) begin
            n_fail++;
            $display("FAIL single_latency got=%0d want=%0d", wr_cyc[base], t + 1);
        end
        n_tests++;
        if (wr_cyc[base+7] - wr_cyc[base] !== 7) begin
            n_fail++;
            $display("FAIL single_span got=%0d want=7",
                     wr_cyc[base+7] - wr_cyc[base]);
        end
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (wr_addr[base+i] !== 10'(i) || wr_dat[base+i] !== (i == 0))
                errs++;
        end
        n_tests++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL single_pixels got=%0d bad want=0 bad", errs);
        end
    endtask

    task automatic test_pending;
        int base;
        int t;
        int errs;
        logic [7:0] b1;
        logic [7:0] b2;
        b1 = 8'hC3;
        b2 = 8'h3C;
        base = wr_n;
        t = cyc;
        rx_data = b1;
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        tick();
        rx_data = b2;
        rx_rdy = 1'b1;
        tick();
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_no_ovf got=%b want=0", overflow);
        end
        rx_data = 8'hFF;
        tick();
        rx_rdy = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_ovf got=%b want=1", overflow);
        end
        repeat (20) tick();
        n_tests++;
        if (wr_n - base !== 16) begin
            n_fail++;
            $display("FAIL pend_count got=%0d want=16", wr_n - base);
        end
        n_tests++;
        if (wr_cyc[base+8] !== t + 10) begin
            n_fail++;
            $display("FAIL pend_latency got=%0d want=%0d", wr_cyc[base+8], t + 10);
        end
        errs = 0;
        for (int i = 0; i < 8; i++) begin
            if (wr_addr[base+i] !== 10'(8 + i) || wr_dat[base+i] !== b1[i])
                errs++;
            if (wr_addr[base+8+i] !== 10'(16 + i) || wr_dat[base+8+i] !== b2[i])
                errs++;
        end
        n_tests++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL pend_pixels got=%0d bad want=0 bad", errs);
        end
    endtask

    task automatic test_frame_a5;
        int base;
        int cs0;
        int errs;
        logic [7:0] pat;
        pat = 8'hA5;
        do_reset();
        base = wr_n;
        cs0 = cs_n;
        for (int i = 0; i < 98; i++)
            send_byte(pat);
        n_tests++;
        if (wr_n - base !== 784) begin
            n_fail++;
            $display("FAIL frame_count got=%0d want=784", wr_n - base);
        end
        errs = 0;
        for (int i = 0; i < 784; i++) begin
            if (wr_addr[base+i] !== 10'(i) || wr_dat[base+i] !== pat[i%8])
                errs++;
        end
        n_tests++;
        if (errs !== 0) begin
            n_fail++;
            $display("FAIL frame_pixels got=%0d bad want=0 bad", errs);
        end
        n_tests++;
        if (wr_addr[base+783] !== 10'h30F) begin
            n_fail++;
            $display("FAIL frame_last_addr got=%h want=30f", wr_addr[base+783]);
        end
        n_tests++;
        if (cs_n - cs0 !== 1) begin
            n_fail++;
            $display("FAIL frame_start_count got=%0d want=1", cs_n - cs0);
        end
        n_tests++;
        if (cs_cyc !== wr_cyc[base+783] + 1) begin
            n_fail++;
            $display("FAIL frame_start_cycle got=%0d want=%0d",
                     cs_cyc, wr_cyc[base+783] + 1);
        end
        n_tests++;
        if ({ram_we, busy, overflow} !== 3'b010) begin
            n_fail++;
            $display("FAIL frame_wait_state got=%b want=010",
                     {ram_we, busy, overflow});
        end
    endtask

    task automatic test_tx_busy;
        int tx0;
        tx0 = tx_n;
        tx_busy = 1'b1;
        core_digit = 4'd7;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (20) tick();
        n_tests++;
        if (tx_n - tx0 !== 0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL txbusy_hold got=%0d/%b want=0/1", tx_n - tx0, busy);
        end
        tx_busy = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (tx_n - tx0 !== 1) begin
            n_fail++;
            $display("FAIL txbusy_count got=%0d want=1", tx_n - tx0);
        end
        n_tests++;
        if (tx_last !== 8'h37 || tx_data !== 8'h37) begin
            n_fail++;
            $display("FAIL txbusy_data got=%h/%h want=37", tx_last, tx_data);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL txbusy_idle got=%b want=0", busy);
        end
        core_digit = 4'd2;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (5) tick();
        n_tests++;
        if (tx_n - tx0 !== 1 || tx_data !== 8'h37) begin
            n_fail++;
            $display("FAIL stray_done got=%0d/%h want=1/37", tx_n - tx0, tx_data);
        end
    endtask

    task automatic test_reset_midframe;
        int base;
        int cs0;
        do_reset();
        for (int i = 0; i < 40; i++)
            send_byte(8'h5A);
        rx_data = 8'h81;
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (ram_we !== 1'b1 || ram_addr !== 10'd323) begin
            n_fail++;
            $display("FAIL mid_unpack got=%b/%0d want=1/323", ram_we, ram_addr);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({ram_we, ram_data, core_start, tx_start, busy, overflow} !== 6'b0 ||
            ram_addr !== 10'd0 || tx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL mid_reset_outs got=%b/%h/%h want=0/000/00",
                     {ram_we, ram_data, core_start, tx_start, busy, overflow},
                     ram_addr, tx_data);
        end
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        base = wr_n;
        cs0 = cs_n;
        for (int i = 0; i < 98; i++)
            send_byte(8'hFF);
        n_tests++;
        if (wr_addr[base] !== 10'd0 || wr_addr[base+783] !== 10'h30F) begin
            n_fail++;
            $display("FAIL mid_restart_addr got=%h..%h want=000..30f",
                     wr_addr[base], wr_addr[base+783]);
        end
        n_tests++;
        if (wr_n - base !== 784 || cs_n - cs0 !== 1) begin
            n_fail++;
            $display("FAIL mid_restart_frame got=%0d/%0d want=784/1",
                     wr_n - base, cs_n - cs0);
        end
    endtask

    task automatic test_bad_digit;
        int tx0;
        n_tests++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ovf_pre got=%b want=0", overflow);
        end
        rx_data = 8'h01;
        rx_rdy = 1'b1;
        tick();
        rx_rdy = 1'b0;
        n_tests++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_ovf got=%b want=1", overflow);
        end
        tx0 = tx_n;
        core_digit = 4'hA;
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (tx_n - tx0 !== 1 || tx_last !== 8'h3F || tx_data !== 8'h3F) begin
            n_fail++;
            $display("FAIL bad_digit got=%0d/%h/%h want=1/3f/3f",
                     tx_n - tx0, tx_last, tx_data);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_pending();
        test_frame_a5();
        test_tx_busy();
        test_reset_midframe();
        test_bad_digit();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
